// File: rtl/lc3_ctrl_seq.sv
// lc3_ctrl_seq: multi-cycle control sequencer for the LC3 core.
// Walks each instruction through fetch, decode, execute, optional data-memory
// phases, writeback and PC update, and resolves branch-taken for the PC mux.
// Optional build macro: LC3_CTRL_TIMEOUT_EN adds a memory-handshake timeout
// that aborts a stuck access and raises a sticky ctrl_err flag.
module lc3_ctrl_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [2:0]  psr,
    input  logic        complete_instr,
    input  logic        complete_data,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        ctrl_err
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM_IND   = 3'd3,
        S_MEM_RD    = 3'd4,
        S_MEM_WR    = 3'd5,
        S_WRITEBACK = 3'd6,
        S_UPDATE_PC = 3'd7
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    state_t     state_q, state_d;
    logic       br_taken_q, br_taken_d;
    logic       tmo_hit;
    logic [3:0] opcode;

    assign opcode = ir[15:12];

    // Operand fields below the BR mask never influence sequencing.
    logic unused_bits;
    assign unused_bits = ^{ir[8:0], TIMEOUT_CYCLES[0]};

`ifdef LC3_CTRL_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ctrl_err_q, ctrl_err_d;
    logic          in_mem;

    // Timeout fires on the last allowed wait cycle when the strobe is still absent.
    always_comb begin
        in_mem  = (state_q == S_MEM_IND) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        tmo_hit = in_mem && !complete_data && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // Wait counter restarts on every state change; error flag is sticky.
    always_comb begin
        tmo_cnt_d  = '0;
        ctrl_err_d = ctrl_err_q | tmo_hit;
        if (in_mem && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q  <= '0;
            ctrl_err_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            ctrl_err_q <= ctrl_err_d;
        end
    end

    assign ctrl_err = ctrl_err_q & ~rst;
`else
    assign tmo_hit  = 1'b0;
    assign ctrl_err = 1'b0;
`endif

    // Next-state and branch-resolution logic.
    always_comb begin
        state_d    = state_q;
        br_taken_d = br_taken_q;
        case (state_q)
            S_FETCH: begin
                if (complete_instr) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                br_taken_d = 1'b0;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = S_WRITEBACK;
                    OP_LD, OP_LDR:                  state_d = S_MEM_RD;
                    OP_ST, OP_STR:                  state_d = S_MEM_WR;
                    OP_LDI, OP_STI:                 state_d = S_MEM_IND;
                    OP_BR: begin
                        state_d    = S_UPDATE_PC;
                        br_taken_d = |(ir[11:9] & psr);
                    end
                    OP_JMP: begin
                        state_d    = S_UPDATE_PC;
                        br_taken_d = 1'b1;
                    end
                    default: state_d = S_UPDATE_PC;
                endcase
            end
            S_MEM_IND: begin
                if (complete_data) begin
                    state_d = (opcode == OP_LDI) ? S_MEM_RD : S_MEM_WR;
                end else if (tmo_hit) begin
                    state_d    = S_UPDATE_PC;
                    br_taken_d = 1'b0;
                end
            end
            S_MEM_RD: begin
                if (complete_data) begin
                    state_d = S_WRITEBACK;
                end else if (tmo_hit) begin
                    state_d    = S_UPDATE_PC;
                    br_taken_d = 1'b0;
                end
            end
            S_MEM_WR: begin
                if (complete_data || tmo_hit) begin
                    state_d = S_UPDATE_PC;
                end
                if (tmo_hit) begin
                    br_taken_d = 1'b0;
                end
            end
            S_WRITEBACK: begin
                state_d = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                state_d    = S_FETCH;
                br_taken_d = 1'b0;
            end
            default: begin
                state_d    = S_FETCH;
                br_taken_d = 1'b0;
            end
        endcase
    end

    // State and branch-taken registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_taken_q <= br_taken_d;
        end
    end

    // Moore output decode; reset forces everything quiet.
    always_comb begin
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        enable_updatePC  = 1'b0;
        mem_state        = 2'd3;
        br_taken         = br_taken_q & ~rst;
        if (!rst) begin
            case (state_q)
                S_FETCH:     enable_fetch     = 1'b1;
                S_DECODE:    enable_decode    = 1'b1;
                S_EXECUTE:   enable_execute   = 1'b1;
                S_MEM_IND:   mem_state        = 2'd2;
                S_MEM_RD:    mem_state        = 2'd0;
                S_MEM_WR:    mem_state        = 2'd1;
                S_WRITEBACK: enable_writeback = 1'b1;
                S_UPDATE_PC: enable_updatePC  = 1'b1;
                default:     mem_state        = 2'd3;
            endcase
        end
    end

endmodule
